xif_timer: RTL and testbench



---
 rtl/xif_timer_pkg.sv | 38 +++
 rtl/xif_timer_presc.sv | 29 ++
 rtl/xif_timer.sv | 193 +++++++++++++++++++
 tb/tb_xif_timer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/xif_timer_pkg.sv
// Shared definitions for the xif timer/compare peripheral: register offsets,
// CTRL/STATUS bit positions, the CTRL layout and a byte-lane merge helper.
package xif_timer_pkg;

    localparam logic [5:0] TMR_CTRL_OFS   = 6'h00;
    localparam logic [5:0] TMR_PRESC_OFS  = 6'h04;
    localparam logic [5:0] TMR_COUNT_OFS  = 6'h08;
    localparam logic [5:0] TMR_CMP_OFS    = 6'h0C;
    localparam logic [5:0] TMR_STATUS_OFS = 6'h10;
    localparam logic [5:0] TMR_CAP_OFS    = 6'h14;

    localparam int CTRL_EN_BIT         = 0;
    localparam int CTRL_IRQ_EN_BIT     = 1;
    localparam int CTRL_AUTORELOAD_BIT = 2;
    localparam int STATUS_PEND_BIT     = 0;
    localparam int STATUS_CAPF_BIT     = 1;

    typedef struct packed {
        logic autoreload;
        logic irq_en;
        logic en;
    } ctrl_t;

    // Replace only the byte lanes selected by be with the new value.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/xif_timer_presc.sv
// Prescaler for the xif timer: counts 0..presc while enabled and emits a
// one-cycle tick on the terminal value.
module xif_timer_presc #(
    parameter int PRESC_W = 16
) (
    input  logic               clk_i,
    input  logic               arst_i,
    input  logic               en,
    input  logic [PRESC_W-1:0] presc,
    input  logic               load,
    output logic               tick
);

    logic [PRESC_W-1:0] pcnt_r;

    assign tick = en && (pcnt_r == presc);

    // Prescale counter; disabled, reloaded or wrapping all restart it at zero.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            pcnt_r <= '0;
        end else if (!en || load || tick) begin
            pcnt_r <= '0;
        end else begin
            pcnt_r <= pcnt_r + PRESC_W'(1);
        end
    end

endmodule

// File: rtl/xif_timer.sv
// Memory-mapped 32-bit timer/compare peripheral on the xif split bus.
// Optional capture input enabled by defining XIF_TIMER_CAPTURE_EN.
module xif_timer
    import xif_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h80000100,
    parameter int          PRESC_W   = 16,
    parameter logic [31:0] RST_CMP   = 32'hFFFFFFFF
) (
    input  logic        clk_i,
    input  logic        arst_i,
`ifdef XIF_TIMER_CAPTURE_EN
    input  logic        capture_i,
`endif
    input  logic        xif_req_i,
    input  logic        xif_we_i,
    input  logic [31:0] xif_addr_bi,
    input  logic [3:0]  xif_be_bi,
    input  logic [31:0] xif_wdata_bi,
    output logic        xif_ack_o,
    output logic        xif_resp_o,
    output logic [31:0] xif_rdata_bo,
    output logic        irq_o
);

    logic               hit_s;
    logic               wr_s;
    logic               rd_s;
    logic [5:0]         ofs_s;
    logic               sel_ctrl_s;
    logic               sel_presc_s;
    logic               sel_count_s;
    logic               sel_cmp_s;
    logic               sel_status_s;
    logic               tick_s;
    logic               match_s;
    logic               presc_load_s;
    logic               w1c_pend_s;
    logic               capf_s;
    logic [31:0]        cap_val_s;
    logic [31:0]        count_tick_s;
    logic [31:0]        rd_mux_s;

    ctrl_t              ctrl_r;
    logic [PRESC_W-1:0] presc_r;
    logic [31:0]        count_r;
    logic [31:0]        cmp_r;
    logic               pend_r;
    logic               resp_r;
    logic [31:0]        rdata_r;
    logic               irq_r;

    assign hit_s        = xif_req_i && (xif_addr_bi[31:6] == BASE_ADDR[31:6]);
    assign wr_s         = hit_s && xif_we_i;
    assign rd_s         = hit_s && !xif_we_i;
    assign ofs_s        = xif_addr_bi[5:0];
    assign sel_ctrl_s   = wr_s && (ofs_s == TMR_CTRL_OFS);
    assign sel_presc_s  = wr_s && (ofs_s == TMR_PRESC_OFS);
    assign sel_count_s  = wr_s && (ofs_s == TMR_COUNT_OFS);
    assign sel_cmp_s    = wr_s && (ofs_s == TMR_CMP_OFS);
    assign sel_status_s = wr_s && (ofs_s == TMR_STATUS_OFS);
    assign presc_load_s = sel_presc_s && (|xif_be_bi);
    assign w1c_pend_s   = sel_status_s && xif_be_bi[0] && xif_wdata_bi[STATUS_PEND_BIT];

    assign xif_ack_o    = hit_s;
    assign xif_resp_o   = resp_r;
    assign xif_rdata_bo = rdata_r;
    assign irq_o        = irq_r;

    xif_timer_presc #(
        .PRESC_W (PRESC_W)
    ) u_presc (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .en     (ctrl_r.en),
        .presc  (presc_r),
        .load   (presc_load_s),
        .tick   (tick_s)
    );

    assign match_s = tick_s && (count_r == cmp_r);

    // Counter value after this cycle's tick, before any software write lands on it.
    always_comb begin
        count_tick_s = count_r;
        if (tick_s) begin
            if (match_s && ctrl_r.autoreload) begin
                count_tick_s = 32'd0;
            end else begin
                count_tick_s = count_r + 32'd1;
            end
        end else begin
            count_tick_s = count_r;
        end
    end

    // Read mux over the current (pre-update) register state.
    always_comb begin
        rd_mux_s = 32'd0;
        case (ofs_s)
            TMR_CTRL_OFS:   rd_mux_s = {29'd0, ctrl_r};
            TMR_PRESC_OFS:  rd_mux_s = 32'(presc_r);
            TMR_COUNT_OFS:  rd_mux_s = count_r;
            TMR_CMP_OFS:    rd_mux_s = cmp_r;
            TMR_STATUS_OFS: begin
                rd_mux_s[STATUS_PEND_BIT] = pend_r;
                rd_mux_s[STATUS_CAPF_BIT] = capf_s;
            end
            TMR_CAP_OFS:    rd_mux_s = cap_val_s;
            default:        rd_mux_s = 32'd0;
        endcase
    end

    // Register file: software writes win over ticks lane by lane; a match wins over W1C.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            ctrl_r  <= '0;
            presc_r <= '0;
            count_r <= 32'd0;
            cmp_r   <= RST_CMP;
            pend_r  <= 1'b0;
        end else begin
            if (sel_ctrl_s && xif_be_bi[0]) begin
                ctrl_r <= ctrl_t'(xif_wdata_bi[CTRL_AUTORELOAD_BIT:CTRL_EN_BIT]);
            end
            if (sel_presc_s) begin
                for (int i = 0; i < PRESC_W; i++) begin
                    if (xif_be_bi[i/8]) begin
                        presc_r[i] <= xif_wdata_bi[i];
                    end
                end
            end
            count_r <= sel_count_s ? merge_lanes(count_tick_s, xif_wdata_bi, xif_be_bi)
                                   : count_tick_s;
            if (sel_cmp_s) begin
                cmp_r <= merge_lanes(cmp_r, xif_wdata_bi, xif_be_bi);
            end
            pend_r <= match_s | (pend_r & ~w1c_pend_s);
        end
    end

`ifdef XIF_TIMER_CAPTURE_EN
    logic [2:0]  cap_sync_r;
    logic [31:0] cap_r;
    logic        capf_r;
    logic        cap_rise_s;
    logic        w1c_capf_s;

    assign cap_rise_s = cap_sync_r[1] & ~cap_sync_r[2];
    assign w1c_capf_s = sel_status_s && xif_be_bi[0] && xif_wdata_bi[STATUS_CAPF_BIT];
    assign capf_s     = capf_r;
    assign cap_val_s  = cap_r;

    // Two-flop synchronizer plus edge history; a rising edge snapshots COUNT.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            cap_sync_r <= 3'b000;
            cap_r      <= 32'd0;
            capf_r     <= 1'b0;
        end else begin
            cap_sync_r <= {cap_sync_r[1:0], capture_i};
            if (cap_rise_s) begin
                cap_r <= count_r;
            end
            capf_r <= cap_rise_s | (capf_r & ~w1c_capf_s);
        end
    end
`else
    assign capf_s    = 1'b0;
    assign cap_val_s = 32'd0;
`endif

    // Read response: one-cycle strobe after accept, data forced to zero otherwise.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            resp_r  <= 1'b0;
            rdata_r <= 32'd0;
        end else begin
            resp_r  <= rd_s;
            rdata_r <= rd_s ? rd_mux_s : 32'd0;
        end
    end

    // Level interrupt, registered from the pending flags gated by IRQ_EN.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= (pend_r | capf_s) & ctrl_r.irq_en;
        end
    end

endmodule

// File: tb/tb_xif_timer.sv
// Directed self-checking bench for xif_timer with a cycle-level behavioural
// model of the register file compared against the DUT on every falling edge.
module tb_xif_timer;

    localparam logic [31:0] BASE = 32'h80000100;

    logic        clk  = 1'b0;
    logic        arst = 1'b1;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ack;
    logic        resp;
    logic [31:0] rdata;
    logic        irq;
    logic [31:0] d;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    xif_timer dut (
        .clk_i        (clk),
        .arst_i       (arst),
        .xif_req_i    (req),
        .xif_we_i     (we),
        .xif_addr_bi  (addr),
        .xif_be_bi    (be),
        .xif_wdata_bi (wdata),
        .xif_ack_o    (ack),
        .xif_resp_o   (resp),
        .xif_rdata_bo (rdata),
        .irq_o        (irq)
    );

    // ---------------- behavioural model ----------------
    logic [2:0]  m_ctrl;
    logic [15:0] m_presc;
    logic [15:0] m_pcnt;
    logic [31:0] m_count;
    logic [31:0] m_cmp;
    logic        m_pend;
    logic        m_irq;
    logic        m_resp;
    logic [31:0] m_rdata;
    logic        m_hit;
    logic        m_wr;
    logic        m_rd;
    logic        m_tick;
    logic        m_match;
    logic [31:0] m_count_t;
    logic [31:0] m_presc_w;

    function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] b);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) r[8*i +: 8] = n[8*i +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] m_reg(input logic [31:0] a);
        if (a[1:0] != 2'b00) return 32'd0;
        case (a[5:2])
            4'd0:    return {29'd0, m_ctrl};
            4'd1:    return {16'd0, m_presc};
            4'd2:    return m_count;
            4'd3:    return m_cmp;
            4'd4:    return {31'd0, m_pend};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_wsel(input logic [3:0] w);
        return m_wr && (addr[5:2] == w) && (addr[1:0] == 2'b00);
    endfunction

    assign m_hit     = req && (addr[31:6] == BASE[31:6]);
    assign m_wr      = m_hit && we;
    assign m_rd      = m_hit && !we;
    assign m_tick    = m_ctrl[0] && (m_pcnt == m_presc);
    assign m_match   = m_tick && (m_count == m_cmp);
    assign m_count_t = !m_tick ? m_count : ((m_match && m_ctrl[2]) ? 32'd0 : m_count + 32'd1);
    assign m_presc_w = lanes({16'd0, m_presc}, wdata, be);

    always @(posedge clk or posedge arst) begin
        if (arst) begin
            m_ctrl  <= 3'd0;
            m_presc <= 16'd0;
            m_pcnt  <= 16'd0;
            m_count <= 32'd0;
            m_cmp   <= 32'hFFFFFFFF;
            m_pend  <= 1'b0;
            m_irq   <= 1'b0;
            m_resp  <= 1'b0;
            m_rdata <= 32'd0;
        end else begin
            m_resp  <= m_rd;
            m_rdata <= m_rd ? m_reg(addr) : 32'd0;
            m_irq   <= m_pend & m_ctrl[1];
            m_pcnt  <= (!m_ctrl[0] || m_tick || (m_wsel(4'd1) && (be != 4'd0))) ? 16'd0
                                                                                : m_pcnt + 16'd1;
            if (m_wsel(4'd0) && be[0]) m_ctrl <= wdata[2:0];
            if (m_wsel(4'd1)) m_presc <= m_presc_w[15:0];
            m_count <= m_wsel(4'd2) ? lanes(m_count_t, wdata, be) : m_count_t;
            if (m_wsel(4'd3)) m_cmp <= lanes(m_cmp, wdata, be);
            m_pend  <= m_match | (m_pend & !(m_wsel(4'd4) && be[0] && wdata[0]));
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!arst) begin
            chk("ack",   {31'd0, ack},  {31'd0, m_hit});
            chk("resp",  {31'd0, resp}, {31'd0, m_resp});
            chk("rdata", rdata,         m_rdata);
            chk("irq",   {31'd0, irq},  {31'd0, m_irq});
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] v, input logic [3:0] b);
        step();
        req = 1'b1; we = 1'b1; addr = a; wdata = v; be = b;
        step();
        req = 1'b0; we = 1'b0; be = 4'd0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        step();
        req = 1'b1; we = 1'b0; addr = a;
        step();
        chk("rd_resp", {31'd0, resp}, 32'd1);
        v = rdata;
        req = 1'b0;
    endtask

    initial begin
        req = 1'b0; we = 1'b0; addr = 32'd0; be = 4'd0; wdata = 32'd0;
        repeat (2) @(negedge clk);
        #1 arst = 1'b0;

        // Reset state
        chk("irq_rst", {31'd0, irq}, 32'd0);
        rd(BASE + 32'h0C, d); chk("cmp_rst", d, 32'hFFFFFFFF);
        rd(BASE + 32'h00, d); chk("ctrl_rst", d, 32'd0);

        // Byte-enable write onto COUNT=0
        wr(BASE + 32'h08, 32'hAABBCCDD, 4'b0010);
        rd(BASE + 32'h08, d); chk("count_be", d, 32'h0000CC00);

        // Period with auto-reload: match on the 5th tick, 20 cycles after enable
        wr(BASE + 32'h08, 32'd0, 4'hF);
        wr(BASE + 32'h04, 32'd3, 4'hF);
        wr(BASE + 32'h0C, 32'd4, 4'hF);
        wr(BASE + 32'h00, 32'd7, 4'hF);
        repeat (20) step();
        chk("irq_before", {31'd0, irq}, 32'd0);
        step();
        chk("irq_rise", {31'd0, irq}, 32'd1);
        rd(BASE + 32'h08, d); chk("count_reload", d, 32'd0);
        rd(BASE + 32'h10, d); chk("pend_set", d, 32'd1);
        wr(BASE + 32'h10, 32'd1, 4'hF);
        step();
        chk("irq_clr", {31'd0, irq}, 32'd0);
        rd(BASE + 32'h10, d); chk("pend_clr", d, 32'd0);
        wr(BASE + 32'h00, 32'd0, 4'hF);

        // Back-to-back reads
        step();
        req = 1'b1; we = 1'b0; addr = BASE + 32'h0C;
        step();
        chk("b2b_cmp", rdata, 32'd4);
        addr = BASE + 32'h04;
        step();
        chk("b2b_presc", rdata, 32'd3);
        req = 1'b0;

        // Wrap without reload
        wr(BASE + 32'h08, 32'hFFFFFFFE, 4'hF);
        wr(BASE + 32'h0C, 32'd5, 4'hF);
        wr(BASE + 32'h04, 32'd0, 4'hF);
        wr(BASE + 32'h00, 32'd1, 4'hF);
        repeat (6) step();
        wr(BASE + 32'h00, 32'd0, 4'hF);
        rd(BASE + 32'h08, d); chk("count_wrap", d, 32'd6);
        rd(BASE + 32'h10, d); chk("pend_wrap", d, 32'd1);
        wr(BASE + 32'h10, 32'd1, 4'hF);

        // W1C colliding with a match
        wr(BASE + 32'h08, 32'd0, 4'hF);
        wr(BASE + 32'h0C, 32'd2, 4'hF);
        wr(BASE + 32'h00, 32'd1, 4'hF);
        step();
        wr(BASE + 32'h10, 32'd1, 4'hF);
        wr(BASE + 32'h00, 32'd0, 4'hF);
        rd(BASE + 32'h10, d); chk("w1c_collide", d, 32'd1);

        // COUNT write on a tick cycle
        wr(BASE + 32'h04, 32'd2, 4'hF);
        wr(BASE + 32'h00, 32'd1, 4'hF);
        step();
        wr(BASE + 32'h08, 32'd100, 4'hF);
        wr(BASE + 32'h00, 32'd0, 4'hF);
        rd(BASE + 32'h08, d); chk("count_tick_wr", d, 32'd100);

        // Outside the window
        step();
        req = 1'b1; we = 1'b0; addr = BASE + 32'h40;
        #1 chk("oow_ack", {31'd0, ack}, 32'd0);
        step();
        chk("oow_resp", {31'd0, resp}, 32'd0);
        req = 1'b0;

        // Async reset mid-count with a read in flight
        wr(BASE + 32'h00, 32'd3, 4'hF);
        step();
        chk("irq_pre_rst", {31'd0, irq}, 32'd1);
        step();
        req = 1'b1; we = 1'b0; addr = BASE + 32'h08;
        @(posedge clk);
        #2;
        req  = 1'b0;
        arst = 1'b1;
        #1;
        chk("rst_resp", {31'd0, resp}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_ack", {31'd0, ack}, 32'd0);
        repeat (2) step();
        arst = 1'b0;
        rd(BASE + 32'h08, d); chk("count_after_rst", d, 32'd0);
        rd(BASE + 32'h0C, d); chk("cmp_after_rst", d, 32'hFFFFFFFF);
        rd(BASE + 32'h00, d); chk("ctrl_after_rst", d, 32'd0);

        repeat (2) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
